mat_mul_ctrl: RTL

MAT_MUL_CTRL -- requirements
Module: mat_mul_ctrl

---
 rtl/mat_mul_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mat_mul_ctrl.sv
// mat_mul_ctrl: sequences clear / stream / drain / done for an MxM systolic multiply.
// Optional abort input is compiled in when MAT_MUL_CTRL_ABORT_EN is defined.
module mat_mul_ctrl #(
    parameter int M = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
`ifdef MAT_MUL_CTRL_ABORT_EN
    input  logic                   abort,
`endif
    output logic [$clog2(M)-1:0]   rd_addr,
    input  logic [8*M-1:0]         a_col,
    input  logic [8*M-1:0]         b_row,
    output logic [8*M-1:0]         a_feed,
    output logic [8*M-1:0]         b_feed,
    output logic                   acc_clr,
    output logic                   busy,
    output logic                   done
);

    localparam int AW = $clog2(M);
    localparam int CW = $clog2(2*M+1);

    // Last count value of STREAM (k = M-1) and of DRAIN (2M cycles)
    localparam logic [CW-1:0] K_LAST = CW'(M-1);
    localparam logic [CW-1:0] D_LAST = CW'(2*M-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          kill;

`ifdef MAT_MUL_CTRL_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and Moore control outputs
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        rd_addr   = '0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                acc_clr   = 1'b1;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                rd_addr = cnt[AW-1:0];
                if (cnt == K_LAST) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt == D_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
        if (kill) begin
            state_nxt = S_IDLE;
        end
    end

    // Per-state cycle counter: zeroed on every transition and while idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (state_nxt != state || state == S_IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Operand feed registers: capture storage data only while streaming
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_feed <= '0;
            b_feed <= '0;
        end else if (state == S_STREAM && !kill) begin
            a_feed <= a_col;
            b_feed <= b_row;
        end else begin
            a_feed <= '0;
            b_feed <= '0;
        end
    end

endmodule
